// File: rtl/leading_zero_counter.sv
// Leading/trailing zero counter built as a balanced priority tree over a power-of-two padded vector.
// Define LZC_OUT_REG_EN to add a reset-able output register stage (1-cycle latency).
module leading_zero_counter #(
  parameter int WIDTH = 2,
  parameter int MODE  = 0,
  localparam int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int NUM_PAD = 2 ** CNT_WIDTH;

  logic [NUM_PAD-1:0]   vec_p0;
  logic [CNT_WIDTH-1:0] cnt_p0;
  logic                 empty_p0;

  // Reversal happens before padding so the zero pad always sits above the searched MSB.
  always_comb begin
    vec_p0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vec_p0[i] = (MODE == 1) ? in_i[WIDTH-1-i] : in_i[i];
    end
  end

  for (genvar l = 0; l < CNT_WIDTH; l++) begin : g_lvl
    logic [2**l-1:0]                vld;
    logic [2**l-1:0][CNT_WIDTH-1:0] idx;

    for (genvar k = 0; k < 2**l; k++) begin : g_node
      if (l == CNT_WIDTH - 1) begin : g_leaf
        assign vld[k] = vec_p0[2*k] | vec_p0[2*k+1];
        assign idx[k] = vec_p0[2*k] ? '0 : CNT_WIDTH'(1);
      end else begin : g_inner
        // Left (lower-index) child wins; choosing the right child sets this level's index bit.
        assign vld[k] = g_lvl[l+1].vld[2*k] | g_lvl[l+1].vld[2*k+1];
        assign idx[k] = g_lvl[l+1].vld[2*k] ? g_lvl[l+1].idx[2*k]
                      : (g_lvl[l+1].idx[2*k+1] | (CNT_WIDTH'(1) << (CNT_WIDTH - 1 - l)));
      end
    end
  end

  assign empty_p0 = ~g_lvl[0].vld[0];
  assign cnt_p0   = g_lvl[0].vld[0] ? g_lvl[0].idx[0] : '0;

`ifdef LZC_OUT_REG_EN
  // Output stage boundary: p0 -> registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o   <= '0;
      empty_o <= 1'b1;
    end else begin
      cnt_o   <= cnt_p0;
      empty_o <= empty_p0;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;
  assign cnt_o   = cnt_p0;
  assign empty_o = empty_p0;
`endif

endmodule

// File: tb/tb_leading_zero_counter.sv
// Scoreboard bench for leading_zero_counter across several WIDTH/MODE instances.
// Works for both the combinational build and the LZC_OUT_REG_EN registered build.
module tb_leading_zero_counter;

`ifdef LZC_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [12:0] in13;
  logic        in1;
  logic [1:0]  in2;
  logic [31:0] in32a, in32b;
  logic [7:0]  in8;

  logic [3:0] c13t, c13l;
  logic       c1t, c1l, c2t, c2l;
  logic [4:0] c32t, c32l;
  logic [2:0] c8;
  logic [8:0] emp_act;
  logic [8:0][4:0] cnt_act;

  leading_zero_counter #(.WIDTH(13), .MODE(0)) u13t (.clk_i(clk), .rst_ni(rst_n), .in_i(in13),  .cnt_o(c13t), .empty_o(emp_act[0]));
  leading_zero_counter #(.WIDTH(13), .MODE(1)) u13l (.clk_i(clk), .rst_ni(rst_n), .in_i(in13),  .cnt_o(c13l), .empty_o(emp_act[1]));
  leading_zero_counter #(.WIDTH(1),  .MODE(0)) u1t  (.clk_i(clk), .rst_ni(rst_n), .in_i(in1),   .cnt_o(c1t),  .empty_o(emp_act[2]));
  leading_zero_counter #(.WIDTH(1),  .MODE(1)) u1l  (.clk_i(clk), .rst_ni(rst_n), .in_i(in1),   .cnt_o(c1l),  .empty_o(emp_act[3]));
  leading_zero_counter #(.WIDTH(2),  .MODE(0)) u2t  (.clk_i(clk), .rst_ni(rst_n), .in_i(in2),   .cnt_o(c2t),  .empty_o(emp_act[4]));
  leading_zero_counter #(.WIDTH(2),  .MODE(1)) u2l  (.clk_i(clk), .rst_ni(rst_n), .in_i(in2),   .cnt_o(c2l),  .empty_o(emp_act[5]));
  leading_zero_counter #(.WIDTH(32), .MODE(0)) u32t (.clk_i(clk), .rst_ni(rst_n), .in_i(in32a), .cnt_o(c32t), .empty_o(emp_act[6]));
  leading_zero_counter #(.WIDTH(32), .MODE(1)) u32l (.clk_i(clk), .rst_ni(rst_n), .in_i(in32b), .cnt_o(c32l), .empty_o(emp_act[7]));
  leading_zero_counter #(.WIDTH(8),  .MODE(0)) u8t  (.clk_i(clk), .rst_ni(rst_n), .in_i(in8),   .cnt_o(c8),   .empty_o(emp_act[8]));

  assign cnt_act[0] = {1'b0, c13t};
  assign cnt_act[1] = {1'b0, c13l};
  assign cnt_act[2] = {4'b0, c1t};
  assign cnt_act[3] = {4'b0, c1l};
  assign cnt_act[4] = {4'b0, c2t};
  assign cnt_act[5] = {4'b0, c2l};
  assign cnt_act[6] = c32t;
  assign cnt_act[7] = c32l;
  assign cnt_act[8] = {2'b0, c8};

  typedef struct {
    int              due;
    logic [8:0][4:0] cnt;
    logic [8:0]      emp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Behavioural scan: walk positions in search order, first set bit gives the count.
  function automatic logic [5:0] scan(input logic [31:0] v, input int w, input bit lead);
    int c = 0;
    bit found = 1'b0;
    for (int i = 0; i < w; i++) begin
      int b = lead ? (w - 1 - i) : i;
      if (!found && v[b]) begin
        found = 1'b1;
        c = i;
      end
    end
    return {~found, c[4:0]};
  endfunction

  task automatic apply(input logic [12:0] v13, input logic v1, input logic [1:0] v2,
                       input logic [31:0] va, input logic [31:0] vb, input logic [7:0] v8);
    logic [5:0] r [9];
    @(posedge clk);
    #1;
    in13 = v13; in1 = v1; in2 = v2; in32a = va; in32b = vb; in8 = v8;
    r[0] = scan({19'b0, v13}, 13, 1'b0);
    r[1] = scan({19'b0, v13}, 13, 1'b1);
    r[2] = scan({31'b0, v1}, 1, 1'b0);
    r[3] = scan({31'b0, v1}, 1, 1'b1);
    r[4] = scan({30'b0, v2}, 2, 1'b0);
    r[5] = scan({30'b0, v2}, 2, 1'b1);
    r[6] = scan(va, 32, 1'b0);
    r[7] = scan(vb, 32, 1'b1);
    r[8] = scan({24'b0, v8}, 8, 1'b0);
    cur.due = cycle + LAT;
    for (int j = 0; j < 9; j++) begin
      cur.cnt[j] = r[j][4:0];
      cur.emp[j] = r[j][5];
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cycle) begin
      exp_t e;
      e = q.pop_front();
      for (int j = 0; j < 9; j++) begin
        check($sformatf("cnt_inst%0d", j), int'(cnt_act[j]), int'(e.cnt[j]));
        check($sformatf("empty_inst%0d", j), int'(emp_act[j]), int'(e.emp[j]));
      end
    end
  end

  // Directed rows: 13-bit input with hand-derived trailing/leading results, plus a 2-bit trailing case.
  logic [12:0] t_v13 [6] = '{13'h0028, 13'h1FFF, 13'h1000, 13'h0000, 13'h0400, 13'h0001};
  logic [1:0]  t_v2  [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
  int          t_ct  [6] = '{3, 0, 12, 0, 10, 0};
  int          t_et  [6] = '{0, 0, 0, 1, 0, 0};
  int          t_cl  [6] = '{7, 0, 0, 0, 2, 12};
  int          t_el  [6] = '{0, 0, 0, 1, 0, 0};
  int          t_c2  [6] = '{1, 0, 0, 0, 1, 0};
  int          t_e2  [6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    logic [31:0] va, vb;
    rst_n = 1'b0;
    in13 = '0; in1 = 1'b0; in2 = '0; in32a = '0; in32b = '0; in8 = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef LZC_OUT_REG_EN
    check("rst_cnt", int'(c8), 0);
    check("rst_empty", int'(emp_act[8]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    in8 = 8'h40;
    #1;
    check("pre_edge_cnt", int'(c8), 0);
    check("pre_edge_empty", int'(emp_act[8]), 1);
    @(posedge clk);
    #1;
    check("post_edge_cnt", int'(c8), 6);
    check("post_edge_empty", int'(emp_act[8]), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", int'(c8), 0);
    check("async_rst_empty", int'(emp_act[8]), 1);
    #1;
    rst_n = 1'b1;
    in8 = 8'h00;
`else
    in8 = 8'h40;
    #1;
    check("comb_in_rst_cnt", int'(c8), 6);
    check("comb_in_rst_empty", int'(emp_act[8]), 0);
    rst_n = 1'b1;
    in8 = 8'h00;
    #1;
    check("comb_zero_cnt", int'(c8), 0);
    check("comb_zero_empty", int'(emp_act[8]), 1);
`endif

    for (int i = 0; i < 6; i++) begin
      apply(t_v13[i], 1'b0, t_v2[i], 32'h0, 32'h0, 8'h0);
      cur.cnt[0] = 5'(t_ct[i]); cur.emp[0] = t_et[i][0];
      cur.cnt[1] = 5'(t_cl[i]); cur.emp[1] = t_el[i][0];
      cur.cnt[4] = 5'(t_c2[i]); cur.emp[4] = t_e2[i][0];
      q.push_back(cur);
    end

    for (int i = 0; i < 4; i++) begin
      logic [1:0] b;
      b = 2'(i);
      apply(13'h0, b[0], b, 32'h8000_0000, 32'h0000_0001, 8'h80);
      q.push_back(cur);
    end

    for (int i = 0; i < 10000; i++) begin
      va = $urandom & $urandom;
      vb = $urandom >> $urandom_range(0, 31);
      if (i % 97 == 0) va = 32'h0;
      if (i % 89 == 0) vb = 32'h0;
      if (i % 7 == 0)  va = 32'h1 << $urandom_range(0, 31);
      if (i % 5 == 0)  vb = 32'h1 << $urandom_range(0, 31);
      apply(13'($urandom & $urandom), 1'($urandom), 2'($urandom), va, vb, 8'($urandom & $urandom));
      q.push_back(cur);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
